shift_oscillator: RTL and testbench
===================================

SHIFT_OSCILLATOR -- requirements
Module: shift_oscillator

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 50, nominal clocks per output half-period; legal range 3..2**CNT_W-2.
REQ-002 SHALL have parameter CNT_W, default 8, width of the phase counter.
REQ-003 SHALL have parameter PEND_MAX, default 7, saturation magnitude of the shift credit; legal range 1..127.
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock; all logic is clocked on the rising edge.
REQ-005 SHALL have port reset_i, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port enable_i, input, 1 bit, run request.
REQ-007 SHALL have port positiveShift_i, input, 1 bit, one-clock pulse requesting a one-clock phase advance.
REQ-008 SHALL have port negativeShift_i, input, 1 bit, one-clock pulse requesting a one-clock phase retard.
REQ-009 SHALL have port signal_o, output, 1 bit, the generated oscillator output.
REQ-010 SHALL have port edge_o, output, 1 bit, one-clock pulse on each signal_o toggle.
REQ-011 SHALL have port phase_o, output, CNT_W bits, the current phase counter value.
REQ-012 SHALL have port pending_o, output, 8 bits signed, the outstanding shift credit.
REQ-013 SHALL have port saturated_o, output, 1 bit, high while |pending_o| == PEND_MAX.

Function
REQ-014 The FSM SHALL have two states: STOP and RUN.
- STOP -> RUN on a clock edge with enable_i=1.
- RUN -> STOP on a clock edge with enable_i=0.
REQ-015 In STOP, the block SHALL hold cnt=0, signal_o=0, edge_o=0, pending=0, limit=HALF_PERIOD, and ignore shift inputs.
REQ-016 In RUN, cnt SHALL increment each clock; when cnt==limit-1, at that edge:
- cnt <- 0;
- signal_o toggles;
- edge_o=1 for that one cycle.
REQ-017 The first signal_o rise SHALL occur exactly HALF_PERIOD edges after the edge entering RUN.
REQ-018 At each toggle edge, the next half-period limit SHALL be:
- HALF_PERIOD-1 if pending>0 (pending decremented by 1);
- HALF_PERIOD+1 if pending<0 (pending incremented by 1);
- HALF_PERIOD otherwise.
REQ-019 At most one adjustment SHALL be applied per half-period.
REQ-020 In RUN, positiveShift_i SHALL add +1 and negativeShift_i SHALL add -1 to pending; both in the same cycle SHALL produce net 0.
REQ-021 Input and consumption effects in the same cycle SHALL be summed before saturation, and the result SHALL clamp to [-PEND_MAX, +PEND_MAX].
REQ-022 A shift pulse SHALL affect limit no earlier than the next toggle edge and SHALL never alter the half-period in progress.
REQ-023 phase_o SHALL equal cnt.
REQ-024 pending_o SHALL equal pending, sign-extended to 8 bits.
REQ-025 All outputs SHALL be registered.
REQ-026 A RUN -> STOP transition mid-half-period SHALL discard cnt and pending at the transition edge.

Reset
REQ-027 reset_i=0 SHALL immediately (asynchronously) force:
- state=STOP, cnt=0, limit=HALF_PERIOD, pending=0;
- signal_o=0, edge_o=0, saturated_o=0.
REQ-028 Reset release SHALL take effect at the first clock edge after reset_i=1; reset asserted mid-operation SHALL behave identically to power-up reset.

Structure
REQ-029 Package pll_pkg SHALL hold:
- the state enum (STOP, RUN);
- the adjust enum (ADJ_NONE, ADJ_ADVANCE, ADJ_RETARD);
- constants DEFAULT_HALF_PERIOD=50 and DEFAULT_PEND_MAX=7.
REQ-030 The saturating up/down credit logic SHALL be a sub-module named shift_credit_counter, with inputs inc, dec, consume_pos, consume_neg and output count.

Verification (HALF_PERIOD=50, PEND_MAX=7, 5 ns clock)
REQ-031 Stimulus: enable_i=1, no shifts. Response: signal_o period 100 clocks, edge_o every 50 clocks, pending_o=0.
REQ-032 Stimulus: one positiveShift_i pulse at cnt=20. Response: the current half-period stays 50, the next is 49, the following is 50; pending_o goes 1 then 0.
REQ-033 Stimulus: ten consecutive negativeShift_i pulses. Response: pending_o saturates at -7 with saturated_o=1, then seven half-periods of 51 follow, then 50.
REQ-034 Stimulus: positiveShift_i and negativeShift_i asserted in the same cycle. Response: pending_o unchanged, period 100.
REQ-035 Stimulus: pending=+1 and a positiveShift_i pulse on the toggle edge. Response: pending_o stays 1; the next half-period is 49, and the one after is also 49.
REQ-036 Stimulus: reset_i=0 and, separately, enable_i=0 at cnt=30. Response:
- reset: outputs are 0 asynchronously;
- enable_i=0: outputs are 0 at the next edge;
- after re-enable, the first rise comes 50 clocks later.

Source files
------------

// File: rtl/pll_pkg.sv
// Shared types and constants for the shift oscillator and its credit counter.
package pll_pkg;

  // Oscillator run state.
  typedef enum logic [0:0] {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Adjustment chosen for the half-period that starts at a toggle edge.
  typedef enum logic [1:0] {
    ADJ_NONE    = 2'd0,
    ADJ_ADVANCE = 2'd1,
    ADJ_RETARD  = 2'd2
  } adj_e;

  localparam int DEFAULT_HALF_PERIOD = 50;
  localparam int DEFAULT_PEND_MAX    = 7;

  // Clamp a signed credit value to [-lim, +lim].
  function automatic logic signed [9:0] clamp_credit(input logic signed [9:0] v,
                                                     input logic signed [9:0] lim);
    logic signed [9:0] r;
    if (v > lim) begin
      r = lim;
    end else if (v < -lim) begin
      r = -lim;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_credit_counter.sv
// Saturating signed up/down counter holding the outstanding phase-shift credit.
// Requests (inc/dec) and consumption at a toggle edge are summed first, then
// the total is clamped to +/-PEND_MAX.
module shift_credit_counter
  import pll_pkg::*;
#(
  parameter int PEND_MAX = DEFAULT_PEND_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              inc,
  input  logic              dec,
  input  logic              consume_pos,
  input  logic              consume_neg,
  output logic signed [7:0] count,
  output logic              saturated
);

  localparam logic signed [9:0] LIM = 10'(PEND_MAX);

  logic signed [9:0] sum;
  logic signed [9:0] next_count;
  logic              next_sat;

  // Sum all same-cycle effects, then clamp.
  always_comb begin
    sum = $signed({{2{count[7]}}, count})
        + (inc         ? 10'sd1 : 10'sd0)
        - (dec         ? 10'sd1 : 10'sd0)
        - (consume_pos ? 10'sd1 : 10'sd0)
        + (consume_neg ? 10'sd1 : 10'sd0);
    next_count = clamp_credit(sum, LIM);
    next_sat   = (next_count == LIM) || (next_count == -LIM);
  end

  // Credit register; cleared whenever the oscillator is not running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 8'sd0;
      saturated <= 1'b0;
    end else if (clear) begin
      count     <= 8'sd0;
      saturated <= 1'b0;
    end else begin
      count     <= next_count[7:0];
      saturated <= next_sat;
    end
  end

endmodule

// File: rtl/shift_oscillator.sv
// Square-wave oscillator whose half-periods can be shortened or lengthened by
// one clock, once per half-period, using an accumulated shift credit.
module shift_oscillator
  import pll_pkg::*;
#(
  parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD,
  parameter int CNT_W       = 8,
  parameter int PEND_MAX    = DEFAULT_PEND_MAX
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              positiveShift_i,
  input  logic              negativeShift_i,
  output logic              signal_o,
  output logic              edge_o,
  output logic [CNT_W-1:0]  phase_o,
  output logic signed [7:0] pending_o,
  output logic              saturated_o
);

  localparam logic [CNT_W-1:0] LIM_NOM   = CNT_W'(HALF_PERIOD);
  localparam logic [CNT_W-1:0] LIM_SHORT = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] LIM_LONG  = CNT_W'(HALF_PERIOD + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  limit;
  logic              signal;
  logic              edge_pulse;
  logic              active;
  logic              toggle;
  adj_e              adj;
  logic signed [7:0] pending;
  logic              sat;

  // Half-period length selected by an adjustment decision.
  function automatic logic [CNT_W-1:0] limit_for(input adj_e a);
    logic [CNT_W-1:0] l;
    case (a)
      ADJ_ADVANCE: l = LIM_SHORT;
      ADJ_RETARD:  l = LIM_LONG;
      ADJ_NONE:    l = LIM_NOM;
      default:     l = LIM_NOM;
    endcase
    return l;
  endfunction

  // Counting only happens on edges where we are already running and stay running;
  // the entry edge and the leaving edge both leave everything cleared.
  assign active = (state == RUN) && enable_i;
  assign toggle = active && (cnt == (limit - CNT_ONE));

  // Pick the adjustment for the next half-period from the credit already held,
  // so a shift arriving on the toggle edge itself waits for the following one.
  always_comb begin
    adj = ADJ_NONE;
    if (toggle) begin
      if (pending > 8'sd0) begin
        adj = ADJ_ADVANCE;
      end else if (pending < 8'sd0) begin
        adj = ADJ_RETARD;
      end else begin
        adj = ADJ_NONE;
      end
    end else begin
      adj = ADJ_NONE;
    end
  end

  // Run/stop state follows enable_i on every edge.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= STOP;
    end else begin
      case (state)
        STOP:    state <= enable_i ? RUN : STOP;
        RUN:     state <= enable_i ? RUN : STOP;
        default: state <= STOP;
      endcase
    end
  end

  // Phase counter, half-period limit, output level and toggle pulse.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt        <= CNT_ZERO;
      limit      <= LIM_NOM;
      signal     <= 1'b0;
      edge_pulse <= 1'b0;
    end else if (!active) begin
      cnt        <= CNT_ZERO;
      limit      <= LIM_NOM;
      signal     <= 1'b0;
      edge_pulse <= 1'b0;
    end else if (toggle) begin
      cnt        <= CNT_ZERO;
      limit      <= limit_for(adj);
      signal     <= ~signal;
      edge_pulse <= 1'b1;
    end else begin
      cnt        <= cnt + CNT_ONE;
      edge_pulse <= 1'b0;
    end
  end

  shift_credit_counter #(
    .PEND_MAX (PEND_MAX)
  ) u_credit (
    .clk         (clk_i),
    .rst_n       (reset_i),
    .clear       (!active),
    .inc         (positiveShift_i & active),
    .dec         (negativeShift_i & active),
    .consume_pos (adj == ADJ_ADVANCE),
    .consume_neg (adj == ADJ_RETARD),
    .count       (pending),
    .saturated   (sat)
  );

  assign signal_o    = signal;
  assign edge_o      = edge_pulse;
  assign phase_o     = cnt;
  assign pending_o   = pending;
  assign saturated_o = sat;

endmodule

// File: tb/tb_shift_oscillator.sv
// Self-checking bench for shift_oscillator: directed scenarios measured as
// half-period lengths, plus randomized shifts against a countdown reference model.
module tb_shift_oscillator;

  localparam int HP = 50;
  localparam int PM = 7;
  localparam int CW = 8;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              enable_i;
  logic              positiveShift_i;
  logic              negativeShift_i;
  logic              signal_o;
  logic              edge_o;
  logic [CW-1:0]     phase_o;
  logic signed [7:0] pending_o;
  logic              saturated_o;

  shift_oscillator #(
    .HALF_PERIOD (HP),
    .CNT_W       (CW),
    .PEND_MAX    (PM)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .enable_i        (enable_i),
    .positiveShift_i (positiveShift_i),
    .negativeShift_i (negativeShift_i),
    .signal_o        (signal_o),
    .edge_o          (edge_o),
    .phase_o         (phase_o),
    .pending_o       (pending_o),
    .saturated_o     (saturated_o)
  );

  always #2.5ns clk_i = ~clk_i;

  int n_checks  = 0;
  int n_pass    = 0;
  int cyc       = 0;
  int last_edge = 0;
  int hp_q[$];
  int off_cnt   = 0;
  int mode      = 0;

  // Reference model: edges left until the next toggle, length of the current half.
  bit m_run, m_sig, m_edge;
  int m_half, m_left, m_pend;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_sig  = 1'b0;
    m_edge = 1'b0;
    m_half = HP;
    m_left = HP;
    m_pend = 0;
  endtask

  task automatic model_step();
    int d;
    if (!m_run) begin
      model_reset();
      m_run = enable_i;
    end else if (!enable_i) begin
      model_reset();
    end else begin
      d = int'(positiveShift_i) - int'(negativeShift_i);
      m_edge = (m_left == 1);
      if (m_edge) begin
        m_sig = !m_sig;
        if (m_pend > 0) begin
          m_half = HP - 1;
          d = d - 1;
        end else if (m_pend < 0) begin
          m_half = HP + 1;
          d = d + 1;
        end else begin
          m_half = HP;
        end
        m_left = m_half;
      end else begin
        m_left = m_left - 1;
      end
      m_pend = m_pend + d;
      if (m_pend > PM) m_pend = PM;
      if (m_pend < -PM) m_pend = -PM;
    end
  endtask

  task automatic compare_model();
    check_eq("signal", int'(signal_o), int'(m_sig));
    check_eq("edge", int'(edge_o), int'(m_edge));
    check_eq("phase", int'(phase_o), m_half - m_left);
    check_eq("pending", int'(pending_o), m_pend);
    check_eq("saturated", int'(saturated_o), int'(m_pend == PM || m_pend == -PM));
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk_i);
    cyc++;
    model_step();
    #1ns;
    compare_model();
    if (edge_o) begin
      hp_q.push_back(cyc - last_edge);
      last_edge = cyc;
    end
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 200; i++) begin
      if (int'(phase_o) == p) return;
      tick();
    end
    check_eq("wait_phase_timeout", int'(phase_o), p);
  endtask

  task automatic collect(input int n);
    for (int i = 0; i < 1200; i++) begin
      if (hp_q.size() >= n) return;
      tick();
    end
    check_eq("collect_timeout", hp_q.size(), n);
  endtask

  task automatic pulse(input logic p, input logic n);
    positiveShift_i = p;
    negativeShift_i = n;
    tick();
    positiveShift_i = 1'b0;
    negativeShift_i = 1'b0;
  endtask

  task automatic start_run();
    enable_i = 1'b1;
    tick();
    last_edge = cyc;
    hp_q.delete();
  endtask

  initial begin
    reset_i         = 1'b1;
    enable_i        = 1'b0;
    positiveShift_i = 1'b0;
    negativeShift_i = 1'b0;
    model_reset();

    // Power-up reset: outputs forced low without any clock edge.
    #1ns reset_i = 1'b0;
    #1ns;
    check_eq("rst_signal", int'(signal_o), 0);
    check_eq("rst_phase", int'(phase_o), 0);
    check_eq("rst_pending", int'(pending_o), 0);
    check_eq("rst_sat", int'(saturated_o), 0);
    @(posedge clk_i);
    #1ns reset_i = 1'b1;
    tick();
    tick();

    // Free run: every half-period is 50 clocks, first rise 50 edges after entry.
    start_run();
    collect(4);
    for (int i = 0; i < 4; i++) check_eq("hp_nominal", hp_q[i], HP);

    // One advance at cnt=20: current 50, next 49, then 50.
    wait_phase(20);
    hp_q.delete();
    pulse(1'b1, 1'b0);
    check_eq("adv_pending", int'(pending_o), 1);
    collect(3);
    check_eq("adv_hp0", hp_q[0], HP);
    check_eq("adv_hp1", hp_q[1], HP - 1);
    check_eq("adv_hp2", hp_q[2], HP);

    // Ten retards saturate at -7, then seven 51-clock halves, then 50.
    wait_phase(5);
    hp_q.delete();
    for (int i = 0; i < 10; i++) pulse(1'b0, 1'b1);
    check_eq("sat_pending", int'(pending_o), -PM);
    check_eq("sat_flag", int'(saturated_o), 1);
    collect(9);
    check_eq("ret_hp0", hp_q[0], HP);
    for (int i = 1; i <= 7; i++) check_eq("ret_hp", hp_q[i], HP + 1);
    check_eq("ret_hp8", hp_q[8], HP);

    // Simultaneous advance and retard cancel.
    wait_phase(10);
    hp_q.delete();
    pulse(1'b1, 1'b1);
    check_eq("both_pending", int'(pending_o), 0);
    collect(2);
    check_eq("both_hp0", hp_q[0], HP);
    check_eq("both_hp1", hp_q[1], HP);

    // Credit +1 plus an advance landing on the toggle edge: 49 then 49.
    wait_phase(10);
    pulse(1'b1, 1'b0);
    wait_phase(HP - 1);
    pulse(1'b1, 1'b0);
    check_eq("tog_edge", int'(edge_o), 1);
    check_eq("tog_pending", int'(pending_o), 1);
    hp_q.delete();
    collect(3);
    check_eq("tog_hp0", hp_q[0], HP - 1);
    check_eq("tog_hp1", hp_q[1], HP - 1);
    check_eq("tog_hp2", hp_q[2], HP);

    // Disable at cnt=30 with credit held: everything cleared at that edge.
    wait_phase(20);
    pulse(1'b1, 1'b0);
    wait_phase(30);
    enable_i = 1'b0;
    tick();
    check_eq("dis_signal", int'(signal_o), 0);
    check_eq("dis_phase", int'(phase_o), 0);
    check_eq("dis_pending", int'(pending_o), 0);
    tick();
    start_run();
    collect(1);
    check_eq("reen_hp", hp_q[0], HP);
    check_eq("reen_rise", int'(signal_o), 1);

    // Mid-run reset at cnt=30 with credit held: asynchronous clear.
    wait_phase(20);
    pulse(1'b0, 1'b1);
    wait_phase(30);
    reset_i = 1'b0;
    #1ns;
    check_eq("mid_rst_signal", int'(signal_o), 0);
    check_eq("mid_rst_phase", int'(phase_o), 0);
    check_eq("mid_rst_pending", int'(pending_o), 0);
    check_eq("mid_rst_sat", int'(saturated_o), 0);
    model_reset();
    @(posedge clk_i);
    #1ns reset_i = 1'b1;
    start_run();
    collect(1);
    check_eq("post_rst_hp", hp_q[0], HP);

    // Randomized shifts with biased phases to reach saturation, and brief disables.
    for (int i = 0; i < 4500; i++) begin
      mode = (i / 500) % 3;
      if (off_cnt > 0) begin
        enable_i = 1'b0;
        off_cnt--;
      end else begin
        enable_i = 1'b1;
        if ($urandom_range(399, 0) == 0) off_cnt = $urandom_range(3, 1);
      end
      case (mode)
        1: begin
          positiveShift_i = ($urandom_range(2, 0) == 0);
          negativeShift_i = ($urandom_range(19, 0) == 0);
        end
        2: begin
          positiveShift_i = ($urandom_range(19, 0) == 0);
          negativeShift_i = ($urandom_range(2, 0) == 0);
        end
        default: begin
          positiveShift_i = ($urandom_range(9, 0) == 0);
          negativeShift_i = ($urandom_range(9, 0) == 0);
        end
      endcase
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
